// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and constants for stream_demux
// Contents: fifo_state_t (EMPTY/ONE/FULL), CW_DEFAULT counter width.
`ifndef WORD
`define WORD 64
`endif

package stream_demux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

   localparam int CW_DEFAULT = 16;

endpackage

// File: rtl/fifo2.sv
// rtl/fifo2.sv - two-entry FIFO with registered head word
// Ports: clk, reset (async, high), push/push_data (caller must not push when full),
//        pop (head consumed), head_data, valid (non-empty), full.
`ifndef WORD
`define WORD 64
`endif

module fifo2
   import stream_demux_pkg::*;
#(
   parameter int N = `WORD
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [N-1:0] push_data,
   input  logic         pop,
   output logic [N-1:0] head_data,
   output logic         valid,
   output logic         full
);

   fifo_state_t  state_q, state_d;
   logic [N-1:0] head_q, head_d;
   logic [N-1:0] tail_q, tail_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               head_d  = push_data;
            end
         end
         ONE: begin
            if (push && pop) begin
               // Old head leaves, new word takes its place.
               head_d = push_data;
            end else if (push) begin
               state_d = FULL;
               tail_d  = push_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // Push is never offered here; the tail just moves up.
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign head_data = head_q;
   assign valid     = (state_q != EMPTY);
   assign full      = (state_q == FULL);

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - steers an input stream to one of two buffered outputs
// Ports: clk, reset (async, high); in_data/in_sel/in_valid/in_ready input stream
//        (in_sel 0 -> A, 1 -> B); a_*/b_* output streams; a_count/b_count
//        delivered-word counters (wrap silently).
`ifndef WORD
`define WORD 64
`endif

module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int N  = `WORD,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  in_data,
   input  logic          in_sel,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  a_data,
   output logic          a_valid,
   input  logic          a_ready,
   output logic [CW-1:0] a_count,
   output logic [N-1:0]  b_data,
   output logic          b_valid,
   input  logic          b_ready,
   output logic [CW-1:0] b_count
);

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic a_full, b_full;
   logic push_a, push_b;
   logic pop_a, pop_b;

   // Readiness looks only at the selected FIFO's fill level, never at the
   // consumers' ready, so a full FIFO refuses even while it is being drained.
   assign in_ready = in_sel ? !b_full : !a_full;

   assign push_a = in_valid && in_ready && !in_sel;
   assign push_b = in_valid && in_ready &&  in_sel;
   assign pop_a  = a_valid && a_ready;
   assign pop_b  = b_valid && b_ready;

   fifo2 #(.N(N)) u_fifo_a (
      .clk       (clk),
      .reset     (reset),
      .push      (push_a),
      .push_data (in_data),
      .pop       (pop_a),
      .head_data (a_data),
      .valid     (a_valid),
      .full      (a_full)
   );

   fifo2 #(.N(N)) u_fifo_b (
      .clk       (clk),
      .reset     (reset),
      .push      (push_b),
      .push_data (in_data),
      .pop       (pop_b),
      .head_data (b_data),
      .valid     (b_valid),
      .full      (b_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_count <= '0;
         b_count <= '0;
      end else begin
         if (pop_a) a_count <= a_count + CNT_ONE;
         if (pop_b) b_count <= b_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux
`ifndef WORD
`define WORD 64
`endif

module tb_stream_demux;

   localparam int N  = 64;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic [N-1:0]  in_data;
   logic          in_sel;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a_data;
   logic          a_valid;
   logic          a_ready;
   logic [CW-1:0] a_count;
   logic [N-1:0]  b_data;
   logic          b_valid;
   logic          b_ready;
   logic [CW-1:0] b_count;

   stream_demux #(.N(N), .CW(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_count  (a_count),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_count  (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one queue per port, capacity two, plus delivered totals.
   logic [N-1:0] qa[$];
   logic [N-1:0] qb[$];
   logic [N-1:0] obs_a[$];
   int           da, db, pushed;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      qa.delete();
      qb.delete();
      da = 0;
      db = 0;
      pushed = 0;
   endtask

   // Compare all outputs with the model, then advance one clock edge.
   task automatic tick();
      bit acc;
      #1;
      check("in_ready", in_ready, (in_sel ? (qb.size() < 2) : (qa.size() < 2)));
      check("a_valid", a_valid, qa.size() > 0);
      check("b_valid", b_valid, qb.size() > 0);
      if (qa.size() > 0) check("a_data", a_data, qa[0]);
      if (qb.size() > 0) check("b_data", b_data, qb[0]);
      check("a_count", a_count, 64'(da % 16));
      check("b_count", b_count, 64'(db % 16));
      if (a_valid && a_ready) obs_a.push_back(a_data);
      @(posedge clk);
      if (!reset) begin
         acc = in_valid && (in_sel ? (qb.size() < 2) : (qa.size() < 2));
         if (qa.size() > 0 && a_ready) begin void'(qa.pop_front()); da++; end
         if (qb.size() > 0 && b_ready) begin void'(qb.pop_front()); db++; end
         if (acc) begin
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
            pushed++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_clear();
      check("rst_in_ready", in_ready, 1);
      check("rst_a_valid", a_valid, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_a_data", a_data, 0);
      check("rst_b_data", b_data, 0);
      check("rst_a_count", a_count, 0);
      check("rst_b_count", b_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      bit seen0;
      int cyc;
      reset    = 1'b1;
      in_data  = '0;
      in_sel   = 1'b0;
      in_valid = 1'b0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      model_clear();
      do_reset();

      // Single word to A, latency one, then delivered.
      in_data = 64'd5; in_sel = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("d1_a_valid", a_valid, 1);
      check("d1_a_data", a_data, 5);
      check("d1_b_valid", b_valid, 0);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("d1_a_count", a_count, 1);

      // Fill A, refuse third word, B still accepted.
      in_valid = 1'b1; in_sel = 1'b0;
      in_data = 64'd10; tick();
      in_data = 64'd20; tick();
      in_data = 64'd30;
      #1;
      check("full_in_ready", in_ready, 0);
      check("full_a_data", a_data, 10);
      in_sel = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FEA2;
      tick();
      check("b_neg_data", b_data, 64'hFFFF_FFFF_FFFF_FEA2);
      check("b_neg_valid", b_valid, 1);

      // Pop on FULL does not admit the waiting word until the next cycle.
      obs_a.delete();
      in_sel = 1'b0; in_data = 64'd30; a_ready = 1'b1;
      #1;
      check("popfull_in_ready", in_ready, 0);
      tick();
      check("after_pop_in_ready", in_ready, 1);
      check("after_pop_a_data", a_data, 20);
      tick();
      in_valid = 1'b0;
      tick();
      a_ready = 1'b0;
      check("order_len", obs_a.size(), 3);
      if (obs_a.size() == 3) begin
         check("order_0", obs_a[0], 10);
         check("order_1", obs_a[1], 20);
         check("order_2", obs_a[2], 30);
      end
      check("a_count_4", a_count, 4);
      b_ready = 1'b1; tick(); b_ready = 1'b0;
      tick();

      // Counter wrap with 17 words through A.
      do_reset();
      seen0 = 0;
      a_ready = 1'b1; in_sel = 1'b0;
      cyc = 0;
      while (da < 17 && cyc < 100) begin
         in_valid = (pushed < 17);
         in_data  = 64'(pushed + 100);
         tick();
         if (da == 15) check("wrap_15", a_count, 15);
         if (da == 16 && !seen0) begin
            check("wrap_0", a_count, 0);
            seen0 = 1;
         end
         cyc++;
      end
      in_valid = 1'b0; a_ready = 1'b0;
      check("wrap_len", da, 17);
      check("wrap_1", a_count, 1);

      // Randomized stream.
      do_reset();
      cyc = 0;
      while (pushed < 1000 && cyc < 20000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_sel   = $urandom_range(0, 1);
         in_data  = {$urandom, $urandom};
         a_ready  = ($urandom_range(0, 4) < 3);
         b_ready  = ($urandom_range(0, 4) < 3);
         tick();
         cyc++;
      end
      check("rand_budget", pushed, 1000);
      in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("rand_drained", qa.size() + qb.size(), 0);
      check("rand_total", da + db, 1000);
      a_ready = 1'b0; b_ready = 1'b0;

      // Asynchronous reset with both FIFOs holding one word.
      in_valid = 1'b1;
      in_sel = 1'b0; in_data = 64'd7; tick();
      in_sel = 1'b1; in_data = 64'd8; tick();
      in_valid = 1'b0;
      check("pre_rst_a_valid", a_valid, 1);
      check("pre_rst_b_valid", b_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      check("async_a_valid", a_valid, 0);
      check("async_b_valid", b_valid, 0);
      check("async_a_count", a_count, 0);
      check("async_b_count", b_count, 0);
      check("async_in_ready", in_ready, 1);
      in_valid = 1'b1; in_sel = 1'b1; in_data = 64'd99;
      tick();
      check("rst_edge_b_valid", b_valid, 0);
      reset = 1'b0;
      in_data = 64'd22;
      tick();
      in_valid = 1'b0;
      check("post_rst_b_data", b_data, 22);
      check("post_rst_a_valid", a_valid, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
